// File: rtl/tx_packet_assembler.sv
// Serializes one captured routing packet into a header-plus-payload word stream
// over a valid/ready handshake; the next packet may be prepared upstream meanwhile.
module tx_packet_assembler #(
  parameter int WORD_WIDTH = 16,
  parameter int SEQ_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic                  txReady,
  output logic [WORD_WIDTH-1:0] txWord,
  output logic                  txValid,
  output logic                  txLast,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_drop,
  output logic                  tx_err
);

  // state | meaning
  // IDLE  | waiting for en; unsupported types flagged on tx_err
  // SEND  | presenting shadow word at idx_q until accepted
  // DONE  | one-cycle completion pulse, sequence number advances
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic                  capture;
  logic                  long_q;
  logic [2:0]            type_q;
  logic [WORD_WIDTH-1:0] src_q, dst_q, hops_q, qv_q, egy_q, ch_q, hch_q;

  logic                  type_ok;
  logic [2:0]            last_idx;
  logic [4:0]            pkt_len;
  logic [WORD_WIDTH-1:0] header;

  assign type_ok  = (rPacketType != 3'd0) && (rPacketType != 3'd7);
  assign last_idx = long_q ? 3'd7 : 3'd5;
  assign pkt_len  = long_q ? 5'd8 : 5'd6;
  assign header   = WORD_WIDTH'({type_q, pkt_len, seq_q});

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // Shadow copy of the packet: the stream never looks at the r* inputs again.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      long_q <= 1'b0;
      type_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      hops_q <= '0;
      qv_q   <= '0;
      egy_q  <= '0;
      ch_q   <= '0;
      hch_q  <= '0;
    end else if (capture) begin
      long_q <= (rPacketType >= 3'd3);
      type_q <= rPacketType;
      src_q  <= rSourceID;
      dst_q  <= rDestinationID;
      hops_q <= rSourceHops;
      qv_q   <= rQValue;
      egy_q  <= rEnergyLeft;
      ch_q   <= rChosenCH;
      hch_q  <= rHopsFromCH;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (type_ok) begin
            capture = 1'b1;
            idx_d   = 3'd0;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        drop_d = en;
        if (txReady) begin
          if (idx_q == last_idx) state_d = DONE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      DONE: begin
        drop_d  = en;
        seq_d   = seq_q + SEQ_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txWord = '0;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    txWord = header;
        3'd1:    txWord = src_q;
        3'd2:    txWord = dst_q;
        3'd3:    txWord = hops_q;
        3'd4:    txWord = qv_q;
        3'd5:    txWord = egy_q;
        3'd6:    txWord = ch_q;
        default: txWord = hch_q;
      endcase
    end
  end

  assign txValid = (state_q == SEND);
  assign txLast  = (state_q == SEND) && (idx_q == last_idx);
  assign busy    = (state_q != IDLE);
  assign tx_done = (state_q == DONE);
  assign tx_err  = err_q;
  assign tx_drop = drop_q;

endmodule

// File: tb/tb_tx_packet_assembler.sv
// Randomized bench for tx_packet_assembler: each packet's expected word list is
// built from the field/length/header rules and compared against the stream.
module tb_tx_packet_assembler;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         nrst, en, txReady;
  logic [2:0]   rPacketType;
  logic [W-1:0] rSourceID, rDestinationID, rSourceHops, rQValue;
  logic [W-1:0] rEnergyLeft, rChosenCH, rHopsFromCH;
  logic [W-1:0] txWord;
  logic         txValid, txLast, busy, tx_done, tx_drop, tx_err;

  tx_packet_assembler #(.WORD_WIDTH(W), .SEQ_WIDTH(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID),
    .rSourceHops(rSourceHops), .rQValue(rQValue), .rEnergyLeft(rEnergyLeft),
    .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH), .txReady(txReady),
    .txWord(txWord), .txValid(txValid), .txLast(txLast), .busy(busy),
    .tx_done(tx_done), .tx_drop(tx_drop), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int           vectors = 0;
  int           miscompares = 0;
  logic [7:0]   model_seq;
  logic [2:0]   p_type;
  logic [W-1:0] p_f [1:7];
  logic [W-1:0] exp_q [$];

  task automatic scramble_inputs();
    rPacketType    = 3'($urandom_range(0, 7));
    rSourceID      = W'($urandom);
    rDestinationID = W'($urandom);
    rSourceHops    = W'($urandom);
    rQValue        = W'($urandom);
    rEnergyLeft    = W'($urandom);
    rChosenCH      = W'($urandom);
    rHopsFromCH    = W'($urandom);
  endtask

  task automatic random_packet(input int lo, input int hi);
    p_type = 3'($urandom_range(lo, hi));
    for (int i = 1; i <= 7; i++) p_f[i] = W'($urandom);
  endtask

  task automatic do_reset();
    en = 1'b0;
    txReady = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_seq = 8'd0;
  endtask

  // Expected stream: header {type, length, seq} followed by length-1 fields.
  task automatic build_expected();
    logic [4:0] len;
    len = (p_type <= 3'd2) ? 5'd6 : 5'd8;
    exp_q.delete();
    exp_q.push_back({p_type, len, model_seq});
    for (int i = 1; i < int'(len); i++) exp_q.push_back(p_f[i]);
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // drop_at: word index at which a second en is injected (-1 none).
  // abort_at: word index at which reset is asserted (-1 none).
  task automatic run_packet(input int rdy_mode, input int drop_at, input int abort_at);
    int idx, cyc, n;
    bit rdy, drop_pending, dropped;
    build_expected();
    n = exp_q.size();
    @(negedge clk);
    rPacketType = p_type;
    rSourceID = p_f[1]; rDestinationID = p_f[2]; rSourceHops = p_f[3];
    rQValue = p_f[4]; rEnergyLeft = p_f[5]; rChosenCH = p_f[6]; rHopsFromCH = p_f[7];
    en = 1'b1;
    txReady = 1'b0;
    @(negedge clk);
    en = 1'b0;
    scramble_inputs();
    vectors++;
    if (tx_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_on_valid_type: tx_err=%b required 0 (type %0d)", tx_err, p_type);
    end
    idx = 0; cyc = 0; drop_pending = 0; dropped = 0;
    while (idx < n && cyc < 200) begin
      if (drop_pending) begin
        drop_pending = 0;
        en = 1'b0;
        vectors++;
        if (tx_drop !== 1'b1) begin
          miscompares++;
          $display("FAIL drop_pulse: tx_drop=%b required 1", tx_drop);
        end
      end
      if (idx == abort_at) begin
        nrst = 1'b0;
        #1;
        vectors++;
        if (txValid !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_async: txValid=%b busy=%b required 0 0", txValid, busy);
        end
        model_seq = 8'd0;
        return;
      end
      vectors++;
      if (txValid !== 1'b1 || busy !== 1'b1 || txWord !== exp_q[idx] ||
          txLast !== (idx == n - 1)) begin
        miscompares++;
        $display("FAIL word[%0d] cyc %0d: valid=%b busy=%b word=%h last=%b required 1 1 %h %b",
                 idx, cyc, txValid, busy, txWord, txLast, exp_q[idx], (idx == n - 1));
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      txReady = rdy;
      if (idx == drop_at && !dropped) begin
        scramble_inputs();
        rPacketType = 3'($urandom_range(1, 6));
        en = 1'b1;
        drop_pending = 1;
        dropped = 1;
      end
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    en = 1'b0;
    txReady = 1'b0;
    vectors++;
    if (cyc >= 200) begin
      miscompares++;
      $display("FAIL timeout: %0d of %0d words transferred in %0d cycles", idx, n, cyc);
      return;
    end
    if (rdy_mode == 0) begin
      vectors++;
      if (cyc != n) begin
        miscompares++;
        $display("FAIL throughput: %0d cycles required %0d", cyc, n);
      end
    end
    if (drop_pending) begin
      vectors++;
      if (tx_drop !== 1'b1) begin
        miscompares++;
        $display("FAIL drop_pulse_last: tx_drop=%b required 1", tx_drop);
      end
    end
    vectors++;
    if (tx_done !== 1'b1 || txValid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done_cycle: done=%b valid=%b busy=%b required 1 0 1", tx_done, txValid, busy);
    end
    @(negedge clk);
    vectors++;
    if (tx_done !== 1'b0 || busy !== 1'b0 || tx_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL back_idle: done=%b busy=%b drop=%b required 0 0 0", tx_done, busy, tx_drop);
    end
    model_seq = model_seq + 8'd1;
  endtask

  task automatic test_reset();
    nrst = 1'b1; en = 1'b0; txReady = 1'b0;
    scramble_inputs();
    #3 nrst = 1'b0;
    #3;
    vectors++;
    if ({txWord, txValid, txLast, busy, tx_done, tx_drop, tx_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: word=%h v=%b l=%b busy=%b done=%b drop=%b err=%b required all 0",
               txWord, txValid, txLast, busy, tx_done, tx_drop, tx_err);
    end
    @(negedge clk);
    nrst = 1'b1;
    model_seq = 8'd0;
    @(negedge clk);
    vectors++;
    if (txValid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: valid=%b busy=%b required 0 0", txValid, busy);
    end
  endtask

  task automatic test_unsupported();
    logic [2:0] bad [2];
    bad[0] = 3'd0;
    bad[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      scramble_inputs();
      rPacketType = bad[k];
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      vectors++;
      if (tx_err !== 1'b1 || txValid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL unsupported_%0d: err=%b valid=%b busy=%b required 1 0 0",
                 bad[k], tx_err, txValid, busy);
      end
      @(negedge clk);
      vectors++;
      if (tx_err !== 1'b0 || txValid !== 1'b0) begin
        miscompares++;
        $display("FAIL err_width_%0d: err=%b valid=%b required 0 0", bad[k], tx_err, txValid);
      end
    end
  endtask

  task automatic test_type1_directed();
    p_type = 3'd1;
    p_f[1] = 16'h000c; p_f[2] = 16'h0001; p_f[3] = 16'h0001;
    p_f[4] = 16'h4000; p_f[5] = 16'h8000; p_f[6] = 16'h1234; p_f[7] = 16'h5678;
    run_packet(0, -1, -1);
  endtask

  task automatic test_backpressure();
    random_packet(3, 3);
    p_f[6] = 16'h0005;
    p_f[7] = 16'h0002;
    run_packet(1, -1, -1);
    for (int k = 0; k < 6; k++) begin
      random_packet(1, 6);
      run_packet(2, -1, -1);
    end
  endtask

  task automatic test_en_while_busy();
    random_packet(3, 6);
    run_packet(0, 2, -1);
    for (int k = 0; k < 6; k++) begin
      random_packet(1, 6);
      run_packet(2, $urandom_range(0, 7), -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      random_packet(1, 6);
      run_packet($urandom_range(0, 2), -1, -1);
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int k = 0; k < 257; k++) begin
      random_packet(1, 1);
      run_packet(0, -1, -1);
    end
  endtask

  task automatic test_reset_mid_packet();
    random_packet(4, 4);
    run_packet(0, -1, 3);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (txValid !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_after_reset: valid=%b busy=%b done=%b required 0 0 0",
                 txValid, busy, tx_done);
      end
    end
    random_packet(4, 4);
    run_packet(0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_unsupported();
    test_type1_directed();
    test_backpressure();
    test_en_while_busy();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
